// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared button FSM encoding and default timing (CLK_HZ, DEBOUNCE_MS, LONG_PRESS_MS)
package stopwatch_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;
  localparam int CLK_HZ = 100_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int LONG_PRESS_MS = 2000;
  function automatic int ms_to_cycles(int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: btn_in raw level in; btn_level, press_pulse, release_pulse, long_press_pulse, run out
interface button_conditioner_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;
  logic run;
  modport master (input btn_in, output btn_level, press_pulse, release_pulse, long_press_pulse, run);
  modport slave (output btn_in, input btn_level, press_pulse, release_pulse, long_press_pulse, run);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop synchroniser; ports clk, reset (async active-low), d (async in), q (synchronised out)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: raw button to debounced level, press/release/long-press pulses and run toggle; ports clk, reset (async active-low), btn (master modport)
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = ms_to_cycles(DEBOUNCE_MS),
  parameter int LONG_PRESS_CYCLES = ms_to_cycles(LONG_PRESS_MS)
) (
  input logic                  clk,
  input logic                  reset,
  button_conditioner_if.master btn
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  btn_state_t state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  logic long_q, long_d, run_q, run_d, long_done_q, long_done_d;
  logic btn_sync;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(btn.btn_in),
    .q(btn_sync)
  );
  // Long press fires on the edge the hold count reaches LONG_PRESS_CYCLES-1,
  // i.e. LONG_PRESS_CYCLES-1 cycles after press_pulse.
  always_comb hold_inc = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    level_d     = level_q;
    run_d       = run_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      IDLE:
        if (btn_sync) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      PRESS_WAIT:
        if (!btn_sync) state_d = IDLE;
        else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          level_d    = 1'b1;
          run_d      = ~run_q;
          hold_cnt_d = '0;
        end else deb_cnt_d = deb_cnt_q + 1'b1;
      PRESSED: begin
        hold_cnt_d = hold_inc;
        if (hold_inc == HOLD_LAST && !long_done_q) begin
          long_d      = 1'b1;
          run_d       = 1'b0;
          long_done_d = 1'b1;
        end
        if (!btn_sync) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        hold_cnt_d = hold_inc;
        if (btn_sync) state_d = PRESSED;
        else if (deb_cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          level_d     = 1'b0;
          long_done_d = 1'b0;
        end else deb_cnt_d = deb_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      run_q       <= 1'b0;
      long_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      run_q       <= run_d;
      long_done_q <= long_done_d;
    end
  assign btn.btn_level        = level_q;
  assign btn.press_pulse      = press_q;
  assign btn.release_pulse    = release_q;
  assign btn.long_press_pulse = long_q;
  assign btn.run              = run_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20
module tb_button_conditioner;
  import stopwatch_pkg::*;
  typedef struct {
    int   kind;
    int   cyc;
    logic run;
    logic lvl;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic exp_run = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  button_conditioner_if bif ();
  button_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(bif.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic hold(logic v, int n);
    bif.btn_in = v;
    repeat (n) @(negedge clk);
  endtask
  // kind: 0 press, 1 release, 2 long press; dly counts from the negedge the input changes
  task automatic expect_ev(int kind, int dly, logic lvl);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + dly;
    e.run  = exp_run;
    e.lvl  = lvl;
    sb.push_back(e);
  endtask
  task automatic drained(string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, expected 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic sb_check(int kind);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.run !== bif.run || e.lvl !== bif.btn_level) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d run=%b lvl=%b, expected kind=%0d cyc=%0d run=%b lvl=%b",
                 kind, cyc, bif.run, bif.btn_level, e.kind, e.cyc, e.run, e.lvl);
      end
    end
  endtask
  always @(negedge clk) begin
    if (bif.press_pulse === 1'b1) sb_check(0);
    if (bif.long_press_pulse === 1'b1) sb_check(2);
    if (bif.release_pulse === 1'b1) sb_check(1);
  end
  initial begin
    bif.btn_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_level", bif.btn_level, 1'b0);
    chk("rst_press", bif.press_pulse, 1'b0);
    chk("rst_release", bif.release_pulse, 1'b0);
    chk("rst_long", bif.long_press_pulse, 1'b0);
    chk("rst_run", bif.run, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 10);
    chk("bounce_level", bif.btn_level, 1'b0);
    chk("bounce_run", bif.run, 1'b0);
    chk("bounce_idle", dut.state_q == IDLE, 1'b1);
    drained("bounce");
    exp_run = ~exp_run;
    expect_ev(0, 7, 1'b1);
    hold(1'b1, 10);
    chk("clean_level", bif.btn_level, 1'b1);
    chk("clean_run", bif.run, 1'b1);
    expect_ev(1, 7, 1'b0);
    hold(1'b0, 12);
    drained("clean");
    exp_run = ~exp_run;
    expect_ev(0, 7, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 2);
    hold(1'b1, 1);
    expect_ev(1, 7, 1'b0);
    hold(1'b0, 10);
    chk("relbounce_run", bif.run, exp_run);
    drained("relbounce");
    exp_run = ~exp_run;
    expect_ev(0, 7, 1'b1);
    exp_run = 1'b0;
    expect_ev(2, 26, 1'b1);
    hold(1'b1, 40);
    expect_ev(1, 7, 1'b0);
    hold(1'b0, 12);
    chk("long_run", bif.run, 1'b0);
    drained("long");
    for (int i = 0; i < 2; i++) begin
      exp_run = ~exp_run;
      expect_ev(0, 7, 1'b1);
      hold(1'b1, 8);
      expect_ev(1, 7, 1'b0);
      hold(1'b0, 10);
      chk("toggle_run", bif.run, exp_run);
    end
    drained("toggle");
    exp_run = ~exp_run;
    expect_ev(0, 7, 1'b1);
    hold(1'b1, 9);
    #2 reset = 1'b0;
    #1;
    chk("midrst_level", bif.btn_level, 1'b0);
    chk("midrst_press", bif.press_pulse, 1'b0);
    chk("midrst_release", bif.release_pulse, 1'b0);
    chk("midrst_long", bif.long_press_pulse, 1'b0);
    chk("midrst_run", bif.run, 1'b0);
    drained("pre_reset");
    exp_run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_run = ~exp_run;
    expect_ev(0, 7, 1'b1);
    hold(1'b1, 10);
    expect_ev(1, 7, 1'b0);
    hold(1'b0, 12);
    drained("after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions one raw push-button input into clean, single-cycle control events for the stopwatch counter's start/stop input, which is clocked by the 10 ms tick domain's source clock.
- Pipeline: synchroniser, then debounce FSM, then edge/long-press event generation.
- A short press toggles a run level. A long press issues a clear pulse and forces run low.
- One instance per front-panel button. Outputs feed the counter's startOrStop and clear inputs directly.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchroniser (minimum 2)
DEBOUNCE_CYCLES, 1000000, cycles btn_in must be stable to accept a press or release (10 ms at 100 MHz)
LONG_PRESS_CYCLES, 200000000, cycles of held press before long_press_pulse fires (2 s at 100 MHz); must exceed DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; the single clock of the block
reset  input  1  asynchronous, active-low reset
btn_in  input  1  raw, asynchronous, bouncing button level (1 = pressed)
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on each accepted press
release_pulse  output  1  one-cycle pulse on each accepted release
long_press_pulse  output  1  one-cycle pulse, at most once per press, when hold time reaches LONG_PRESS_CYCLES
run  output  1  start/stop level; toggles on each press_pulse, cleared by long press

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, synchroniser flops 0, FSM in IDLE, both counters 0.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-press aborts it: no pulses are emitted, and btn_in must be seen high again from IDLE.
- Synchroniser: btn_sync = btn_in delayed by SYNC_STAGES flops. No logic between stages.
- Counters:
  - deb_cnt: width $clog2(DEBOUNCE_CYCLES).
  - hold_cnt: width $clog2(LONG_PRESS_CYCLES), saturating at LONG_PRESS_CYCLES-1, never wraps.
- FSM states and transitions (registered):
  - IDLE: btn_sync=1 -> PRESS_WAIT, deb_cnt<=0.
  - PRESS_WAIT:
    - btn_sync=0 -> IDLE (bounce rejected, no pulse).
    - Otherwise deb_cnt++.
    - When deb_cnt==DEBOUNCE_CYCLES-1 and btn_sync=1 -> PRESSED: press_pulse<=1, btn_level<=1, run<=~run, hold_cnt<=0.
  - PRESSED:
    - hold_cnt++ (saturating).
    - When hold_cnt==LONG_PRESS_CYCLES-1 and the long-press flag is clear: long_press_pulse<=1, run<=0, set the flag.
    - btn_sync=0 -> RELEASE_WAIT, deb_cnt<=0.
  - RELEASE_WAIT:
    - hold_cnt keeps counting.
    - btn_sync=1 -> PRESSED (release bounce; no new press_pulse, hold_cnt not reset).
    - Otherwise deb_cnt++.
    - When deb_cnt==DEBOUNCE_CYCLES-1 and btn_sync=0 -> IDLE: release_pulse<=1, btn_level<=0, clear the long-press flag.
- Pulses are high for exactly one cycle. Each is registered and deasserted on the following edge.
- Latency:
  - Take edge 0 as the first edge sampling btn_in=1, with btn_in held stable.
  - press_pulse, btn_level and run are updated at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Release latency is symmetric.
- Simultaneous events: if the long-press threshold is reached on the same edge btn_sync falls, long_press_pulse still fires and the FSM moves to RELEASE_WAIT.
- Within one press the order is: press_pulse, then long_press_pulse, then release_pulse. Only press_pulse toggles run.
- Glitches shorter than DEBOUNCE_CYCLES after synchronisation never change btn_level and never produce pulses.

Decomposition:
- Shared package/header stopwatch_pkg:
  - FSM state encodings (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
  - Default timing constants CLK_HZ, DEBOUNCE_MS, LONG_PRESS_MS.
- One sub-module, sync_ff: a parameterised SYNC_STAGES-deep synchroniser with async active-low reset. It is reused for the other panel inputs.
- FSM and counters stay in button_conditioner.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
- Clean press: btn_in 0->1 at edge 0, held 10 cycles -> press_pulse=1 only in the cycle after edge 6; btn_level=1 from then; run 0->1.
- Bounce rejection: btn_in high 3 cycles, low 2, high 3, low -> no press_pulse; btn_level stays 0; run stays 0; FSM returns to IDLE.
- Release with bounce: after an accepted press, btn_in low 2, high 1, low 10 -> exactly one release_pulse, 6 cycles after the final fall; no second press_pulse; run unchanged.
- Long press: press held 40 cycles -> press_pulse (run=1), then one long_press_pulse 19 cycles after press_pulse (run=0), no repeat while held, release_pulse on release.
- Toggle: two short presses separated by 10 idle cycles -> run goes 0->1->0; two press_pulse and two release_pulse total.
- Async reset mid-press: reset=0 asserted during PRESSED between clock edges -> all outputs 0 immediately; after release of reset with btn_in still high, press_pulse fires again only after the full 6-edge latency.
